// File: rtl/vend_credit_controller_pkg.sv
// Shared types and tables for the vending credit controller: state encoding,
// coin values, item prices and the credit ceiling.
package vend_credit_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } vend_state_e;

   localparam int         CREDIT_W   = 5;
   localparam logic [4:0] CREDIT_MAX = 5'd31;

   // Coin value table: code 0..3 -> 1, 2, 5, 10 units.
   function automatic logic [4:0] coin_value(input logic [1:0] code);
      logic [4:0] value;
      case (code)
         2'd0:    value = 5'd1;
         2'd1:    value = 5'd2;
         2'd2:    value = 5'd5;
         2'd3:    value = 5'd10;
         default: value = 5'd0;
      endcase
      return value;
   endfunction

   // Price table: item 0..3 -> 3, 7, 12, 25 units.
   function automatic logic [4:0] item_price(input logic [1:0] item);
      logic [4:0] price;
      case (item)
         2'd0:    price = 5'd3;
         2'd1:    price = 5'd7;
         2'd2:    price = 5'd12;
         2'd3:    price = 5'd25;
         default: price = 5'd31;
      endcase
      return price;
   endfunction

endpackage

// File: rtl/vend_credit_controller_bin5_to_bcd.sv
// Combinational 5-bit binary (0-31) to two-digit BCD converter.
module bin5_to_bcd (
   input  logic [4:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   // Range-compare conversion; 31 is small enough that a subtract chain beats double-dabble.
   always_comb begin
      tens = 4'd0;
      ones = 4'd0;
      if (bin >= 5'd30) begin
         tens = 4'd3;
         ones = 4'(bin - 5'd30);
      end else if (bin >= 5'd20) begin
         tens = 4'd2;
         ones = 4'(bin - 5'd20);
      end else if (bin >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(bin - 5'd10);
      end else begin
         tens = 4'd0;
         ones = 4'(bin);
      end
   end

endmodule

// File: rtl/vend_credit_controller.sv
// Vending machine credit controller: accumulates coins, sells items, dispenses
// for a fixed number of cycles and pays change back one unit per cycle.
module vend_credit_controller
   import vend_credit_controller_pkg::*;
#(
   parameter int VEND_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   input  logic       buy,
   input  logic [1:0] item_sel,
   input  logic       cancel,
   output logic [4:0] credit,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic       coin_reject,
   output logic       deny,
   output logic       dispense_on,
   output logic       change_pulse,
   output logic       busy
);

   // Counter runs VEND_CYCLES-1 down to 0, so dispense_on spans VEND_CYCLES cycles.
   localparam logic [3:0] VEND_CNT_INIT = 4'(VEND_CYCLES - 1);

   vend_state_e state_r, state_s;
   logic [4:0]  credit_r, credit_s;
   logic [3:0]  vend_cnt_r, vend_cnt_s;
   logic        coin_reject_r, coin_reject_s;
   logic        deny_r, deny_s;
   logic        dispense_r, dispense_s;
   logic        change_pulse_r, change_pulse_s;
   logic        busy_r, busy_s;

   logic [5:0]  coin_sum_s;
   logic [4:0]  price_s;

   assign coin_sum_s = {1'b0, credit_r} + {1'b0, coin_value(coin_type)};
   assign price_s    = item_price(item_sel);

   // Next-state and next-output logic; priority among strobes is cancel > buy > coin.
   always_comb begin
      state_s        = state_r;
      credit_s       = credit_r;
      vend_cnt_s     = vend_cnt_r;
      coin_reject_s  = 1'b0;
      deny_s         = 1'b0;
      dispense_s     = 1'b0;
      change_pulse_s = 1'b0;
      busy_s         = 1'b0;

      case (state_r)
         ST_IDLE, ST_CREDIT: begin
            if (cancel && (state_r == ST_CREDIT)) begin
               state_s       = ST_CHANGE;
               coin_reject_s = coin_valid;
            end else if (buy) begin
               coin_reject_s = coin_valid;
               if ((state_r == ST_CREDIT) && (credit_r >= price_s)) begin
                  state_s    = ST_VEND;
                  credit_s   = credit_r - price_s;
                  vend_cnt_s = VEND_CNT_INIT;
                  dispense_s = 1'b1;
               end else begin
                  deny_s = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_sum_s <= {1'b0, CREDIT_MAX}) begin
                  credit_s = coin_sum_s[4:0];
                  state_s  = ST_CREDIT;
               end else begin
                  coin_reject_s = 1'b1;
               end
            end else begin
               state_s = state_r;
            end
         end

         ST_VEND: begin
            coin_reject_s = coin_valid;
            if (vend_cnt_r == 4'd0) begin
               dispense_s = 1'b0;
               state_s    = (credit_r != 5'd0) ? ST_CHANGE : ST_IDLE;
            end else begin
               vend_cnt_s = vend_cnt_r - 4'd1;
               dispense_s = 1'b1;
            end
         end

         ST_CHANGE: begin
            // The final pulse is emitted while still in CHANGE; IDLE follows a cycle later.
            coin_reject_s = coin_valid;
            if (credit_r != 5'd0) begin
               credit_s       = credit_r - 5'd1;
               change_pulse_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         default: begin
            state_s    = ST_IDLE;
            credit_s   = 5'd0;
            vend_cnt_s = 4'd0;
         end
      endcase

      busy_s = (state_s == ST_VEND) || (state_s == ST_CHANGE);
   end

   // State and registered outputs; reset aborts any vend or change in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         credit_r       <= 5'd0;
         vend_cnt_r     <= 4'd0;
         coin_reject_r  <= 1'b0;
         deny_r         <= 1'b0;
         dispense_r     <= 1'b0;
         change_pulse_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         state_r        <= state_s;
         credit_r       <= credit_s;
         vend_cnt_r     <= vend_cnt_s;
         coin_reject_r  <= coin_reject_s;
         deny_r         <= deny_s;
         dispense_r     <= dispense_s;
         change_pulse_r <= change_pulse_s;
         busy_r         <= busy_s;
      end
   end

   bin5_to_bcd u_bcd (
      .bin  (credit_r),
      .tens (bcd_tens),
      .ones (bcd_ones)
   );

   assign credit       = credit_r;
   assign coin_reject  = coin_reject_r;
   assign deny         = deny_r;
   assign dispense_on  = dispense_r;
   assign change_pulse = change_pulse_r;
   assign busy         = busy_r;

endmodule

// File: tb/tb_vend_credit_controller.sv
// Self-checking bench: directed scenarios plus random strobes, every cycle
// compared against a behavioural credit/vend/change model.
module tb_vend_credit_controller;

   localparam int VEND_CYCLES = 4;

   logic       clk;
   logic       reset;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       buy;
   logic [1:0] item_sel;
   logic       cancel;
   logic [4:0] credit;
   logic [3:0] bcd_tens;
   logic [3:0] bcd_ones;
   logic       coin_reject;
   logic       deny;
   logic       dispense_on;
   logic       change_pulse;
   logic       busy;

   vend_credit_controller #(.VEND_CYCLES(VEND_CYCLES)) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .buy          (buy),
      .item_sel     (item_sel),
      .cancel       (cancel),
      .credit       (credit),
      .bcd_tens     (bcd_tens),
      .bcd_ones     (bcd_ones),
      .coin_reject  (coin_reject),
      .deny         (deny),
      .dispense_on  (dispense_on),
      .change_pulse (change_pulse),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: credit in units, dispense cycles still owed, paying-change flag.
   int coin_tab [4] = '{1, 2, 5, 10};
   int price_tab[4] = '{3, 7, 12, 25};
   int m_credit = 0;
   int m_vend_left = 0;
   int m_changing = 0;
   int e_rej = 0;
   int e_deny = 0;
   int e_pulse = 0;

   int n_disp = 0;
   int n_pulse = 0;
   int n_rej = 0;
   int n_deny = 0;

   task automatic check_eq(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic model_update(input logic rs, input logic cv, input logic [1:0] ct,
                               input logic b, input logic [1:0] is, input logic cn);
      e_rej = 0; e_deny = 0; e_pulse = 0;
      if (rs) begin
         m_credit = 0; m_vend_left = 0; m_changing = 0;
      end else if (m_vend_left > 0) begin
         e_rej = int'(cv);
         m_vend_left--;
         if (m_vend_left == 0 && m_credit > 0) m_changing = 1;
      end else if (m_changing != 0) begin
         e_rej = int'(cv);
         if (m_credit > 0) begin
            m_credit--;
            e_pulse = 1;
         end else begin
            m_changing = 0;
         end
      end else if (cn && m_credit > 0) begin
         m_changing = 1;
         e_rej = int'(cv);
      end else if (b) begin
         e_rej = int'(cv);
         if (m_credit > 0 && m_credit >= price_tab[is]) begin
            m_credit -= price_tab[is];
            m_vend_left = VEND_CYCLES;
         end else begin
            e_deny = 1;
         end
      end else if (cv) begin
         if (m_credit + coin_tab[ct] <= 31) m_credit += coin_tab[ct];
         else e_rej = 1;
      end
   endtask

   task automatic compare_all();
      check_eq("credit", int'(credit), m_credit);
      check_eq("bcd_tens", int'(bcd_tens), m_credit / 10);
      check_eq("bcd_ones", int'(bcd_ones), m_credit % 10);
      check_eq("coin_reject", int'(coin_reject), e_rej);
      check_eq("deny", int'(deny), e_deny);
      check_eq("dispense_on", int'(dispense_on), (m_vend_left > 0) ? 1 : 0);
      check_eq("change_pulse", int'(change_pulse), e_pulse);
      check_eq("busy", int'(busy), (m_vend_left > 0 || m_changing != 0) ? 1 : 0);
      n_disp  += int'(dispense_on);
      n_pulse += int'(change_pulse);
      n_rej   += int'(coin_reject);
      n_deny  += int'(deny);
   endtask

   // One clock: drive inputs, let the DUT and model take the edge, compare on the falling edge.
   task automatic step(input logic rs, input logic cv, input logic [1:0] ct,
                       input logic b, input logic [1:0] is, input logic cn);
      reset = rs; coin_valid = cv; coin_type = ct; buy = b; item_sel = is; cancel = cn;
      @(posedge clk);
      model_update(rs, cv, ct, b, is, cn);
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic coin(input logic [1:0] ct);
      step(1'b0, 1'b1, ct, 1'b0, 2'd0, 1'b0);
   endtask

   task automatic clear_counts();
      n_disp = 0; n_pulse = 0; n_rej = 0; n_deny = 0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (busy && n < 60) begin
         idle_step();
         n++;
      end
      check_eq(tag, int'(busy), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; coin_valid = 1'b0; coin_type = 2'd0;
      buy = 1'b0; item_sel = 2'd0; cancel = 1'b0;
      @(negedge clk);
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      check_eq("reset_credit", int'(credit), 0);
      check_eq("reset_busy", int'(busy), 0);

      // Coins 10,10,5 -> 25
      clear_counts();
      coin(2'd3); coin(2'd3); coin(2'd2);
      check_eq("s1_credit", int'(credit), 25);
      check_eq("s1_tens", int'(bcd_tens), 2);
      check_eq("s1_ones", int'(bcd_ones), 5);
      check_eq("s1_rejects", n_rej, 0);

      // Overflow coin rejected, then fill to exactly 31
      coin(2'd3);
      check_eq("s2_reject", int'(coin_reject), 1);
      check_eq("s2_credit_hold", int'(credit), 25);
      coin(2'd2);
      check_eq("s2_reject_clear", int'(coin_reject), 0);
      coin(2'd0);
      check_eq("s2_credit31", int'(credit), 31);
      check_eq("s2_tens", int'(bcd_tens), 3);
      check_eq("s2_ones", int'(bcd_ones), 1);

      // Credit 10, buy item1 -> 4 dispense cycles, 3 change pulses
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      coin(2'd3);
      clear_counts();
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
      check_eq("s3_credit_after_buy", int'(credit), 3);
      drain("s3_finished");
      check_eq("s3_dispense_cycles", n_disp, 4);
      check_eq("s3_change_pulses", n_pulse, 3);
      check_eq("s3_final_credit", int'(credit), 0);

      // Credit 5, buy item2 -> deny
      coin(2'd2);
      clear_counts();
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
      check_eq("s4_deny", int'(deny), 1);
      check_eq("s4_credit", int'(credit), 5);
      check_eq("s4_not_busy", int'(busy), 0);
      idle_step();
      check_eq("s4_deny_pulse", n_deny, 1);

      // Credit 12, cancel+buy+coin together -> cancel wins
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      coin(2'd3); coin(2'd1);
      clear_counts();
      step(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1);
      check_eq("s5_coin_reject", int'(coin_reject), 1);
      drain("s5_finished");
      check_eq("s5_change_pulses", n_pulse, 12);
      check_eq("s5_no_dispense", n_disp, 0);
      check_eq("s5_reject_once", n_rej, 1);

      // Credit 8, buy item0 -> 5 change; coin during VEND; reset on 2nd pulse
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      coin(2'd2); coin(2'd1); coin(2'd0);
      step(1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      coin(2'd0);
      check_eq("s6_vend_coin_reject", int'(coin_reject), 1);
      check_eq("s6_credit", int'(credit), 5);
      clear_counts();
      for (int i = 0; i < 40 && n_pulse < 2; i++) idle_step();
      check_eq("s6_second_pulse", n_pulse, 2);
      step(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
      clear_counts();
      for (int i = 0; i < 8; i++) idle_step();
      check_eq("s6_no_more_pulses", n_pulse, 0);
      check_eq("s6_credit_zero", int'(credit), 0);
      check_eq("s6_idle", int'(busy), 0);

      // Random strobes against the model
      for (int i = 0; i < 1500; i++) begin
         logic rs, cv, b, cn;
         logic [1:0] ct, is;
         rs = ($urandom_range(0, 149) == 0);
         cv = ($urandom_range(0, 9) < 4);
         b  = ($urandom_range(0, 9) < 2);
         cn = ($urandom_range(0, 19) == 0);
         ct = 2'($urandom_range(0, 3));
         is = 2'($urandom_range(0, 3));
         step(rs, cv, ct, b, is, cn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_credit_controller.md
VEND_CREDIT_CONTROLLER -- requirements
Module: vend_credit_controller

Interface
REQ-001 Parameter VEND_CYCLES, default 4, meaning: number of cycles dispense_on is held high per vend (range 1-15).
REQ-002 Port clk  input  1  rising-edge system clock; all state changes on the rising edge of clk.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port coin_valid  input  1  one-cycle strobe indicating a coin was inserted.
REQ-005 Port coin_type  input  2  coin value code, sampled with coin_valid: 0=1 unit, 1=2 units, 2=5 units, 3=10 units.
REQ-006 Port buy  input  1  one-cycle purchase request strobe.
REQ-007 Port item_sel  input  2  item code, sampled with buy; prices come from the package price table.
REQ-008 Port cancel  input  1  one-cycle strobe requesting return of all credit.
REQ-009 Port credit  output  5  current credit in units, 0-31.
REQ-010 Port bcd_tens  output  4  BCD tens digit of credit (0-3).
REQ-011 Port bcd_ones  output  4  BCD ones digit of credit (0-9).
REQ-012 Port coin_reject  output  1  one-cycle pulse indicating the coin was not accepted.
REQ-013 Port deny  output  1  one-cycle pulse indicating the purchase was refused.
REQ-014 Port dispense_on  output  1  high while the item is being dispensed.
REQ-015 Port change_pulse  output  1  one-cycle pulse per unit of change returned.
REQ-016 Port busy  output  1  high in every state except IDLE and CREDIT.

Function
REQ-017 The block SHALL implement the states IDLE, CREDIT, VEND and CHANGE.
REQ-018 IDLE: credit==0; an accepted coin moves to CREDIT.
REQ-019 CREDIT: credit>0; coins are accepted, buy and cancel are honoured.
REQ-020 Coin acceptance: in IDLE/CREDIT, if credit+value<=31 the credit SHALL update on the next edge; otherwise credit is unchanged and coin_reject pulses on the next cycle.
REQ-021 Coins arriving in VEND or CHANGE SHALL be rejected with a coin_reject pulse.
REQ-022 Buy in CREDIT with credit>=price: next cycle enter VEND, credit SHALL become credit-price, and dispense_on SHALL be high for exactly VEND_CYCLES cycles.
REQ-023 Buy with credit<price, or buy in IDLE: deny pulses next cycle; state and credit unchanged.
REQ-024 Buy in VEND or CHANGE SHALL be ignored, with no deny pulse.
REQ-025 VEND exit: go to CHANGE if credit>0, else IDLE.
REQ-026 CHANGE: each cycle, change_pulse=1 and credit decrements by 1; when credit reaches 0, go to IDLE (the cycle after the last pulse).
REQ-027 Cancel in CREDIT SHALL enter CHANGE next cycle; cancel in IDLE, VEND or CHANGE is ignored.
REQ-028 Simultaneous strobes in one cycle, priority cancel > buy > coin; the losing coin SHALL be rejected with coin_reject; a losing buy is dropped silently.
REQ-029 bcd_tens/bcd_ones SHALL be a combinational function of registered credit (zero added latency), e.g. 31 -> 3,1; 10 -> 1,0.
REQ-030 All outputs except the BCD digits SHALL be registered.

Reset
REQ-031 Reset SHALL force state IDLE, credit=0, clear the vend counter, and drive all pulse outputs, dispense_on and busy to 0 on the next edge.
REQ-032 Reset asserted mid-VEND or mid-CHANGE SHALL abort immediately; the remaining change is discarded and no further pulses are issued.

Structure
REQ-033 A shared package SHALL hold the state enum, the coin value table {1,2,5,10}, the price table (item0=3, item1=7, item2=12, item3=25) and CREDIT_MAX=31.
REQ-034 The binary-to-BCD mapping SHALL be one combinational sub-module, bin5_to_bcd (5-bit in, two 4-bit digits out).

Verification
REQ-035 The bench SHALL cover each scenario below.
- Reset, then coins 10,10,5 -> credit 25, BCD 2/5, state CREDIT, no reject.
- credit 25 + coin 10 -> coin_reject one cycle, credit stays 25; coin 5 then coin 1 -> credit 31.
- credit 10, buy item1 -> dispense_on high 4 cycles, credit 3, then exactly 3 change_pulse, IDLE, credit 0.
- credit 5, buy item2 -> deny one cycle, credit 5, state CREDIT.
- credit 12 with cancel+buy+coin in the same cycle -> 12 change_pulse, no dispense, coin_reject once.
- Reset asserted during the 2nd change_pulse of 5 -> no further pulses, credit 0, IDLE; a coin inserted during VEND -> rejected.
